demux1x2_reg: RTL and testbench
===============================

// Module: demux1x2_reg
// PURPOSE
//  Registered 1-to-2 demultiplexer: the inverse of the 32-bit 2:1 datapath mux.
//  Routes each word of one valid/ready input stream to output A (sel=0) or output B (sel=1).
//  Each output has a one-entry holding register, so a stalled output does not block the other.
//  Sits in the lab datapath wherever one producer feeds two consumers, e.g. write-back fan-out.
// PARAMETERS
//  WIDTH  32  data word width in bits
//  CNT_W  16  width of the per-output delivered-word counters
// PORTS
//  Clk         in   1      rising-edge clock, single clock domain
//  Reset       in   1      synchronous, active-high reset
//  in_data     in   WIDTH  input word
//  in_sel      in   1      destination: 0 -> A, 1 -> B; sampled with in_data
//  in_valid    in   1      in_data/in_sel are valid
//  in_ready    out  1      block accepts the word this cycle
//  outA_data   out  WIDTH  output A word (registered)
//  outA_valid  out  1      output A holds a word
//  outA_ready  in   1      consumer A takes the word this cycle
//  outB_data   out  WIDTH  output B word (registered)
//  outB_valid  out  1      output B holds a word
//  outB_ready  in   1      consumer B takes the word this cycle
//  cntA        out  CNT_W  words delivered on A since reset
//  cntB        out  CNT_W  words delivered on B since reset
// BEHAVIOUR
//  - Reset (sync, active-high): outX_valid=0, outX_data=0, cntA=cntB=0; slot FSMs -> EMPTY.
//    in_ready=0 while Reset=1. Words held at reset are dropped and not counted.
//  - Each output slot has a 2-state FSM:
//    EMPTY->FULL on load. FULL->EMPTY on drain without load. FULL->FULL on drain+load, or on hold.
//  - outX_valid = (slot X == FULL). outX_data changes only on a load.
//  - Drain X: outX_valid && outX_ready at a rising edge.
//  - in_ready = !Reset && (slot[in_sel] EMPTY || drain of slot[in_sel] this cycle).
//    in_ready is combinational from in_sel, slot state and outX_ready.
//    It depends only on the selected slot.
//  - Accept: in_valid && in_ready. The word loads into slot[in_sel] at that edge.
//    Latency 1: outX_valid rises the cycle after accept.
//    Throughput 1 word/cycle per output when the consumer holds ready=1.
//  - Simultaneous drain and load of the same slot: the new word replaces the old.
//    valid stays 1 with no bubble. The counter increments for the drained word.
//  - The non-selected slot is unaffected by the input and may drain in the same cycle.
//  - Input stays stable while in_valid && !in_ready; the block does not check this.
//  - A word is never duplicated, dropped (except at reset), or sent to the wrong output.
//  - cntX increments by 1 on each drain of X. It wraps from 2^CNT_W-1 to 0; no saturation.
// STRUCTURE
//  - Shared package demux_pkg: slot_state_t {SLOT_EMPTY, SLOT_FULL}; SEL_A=1'b0, SEL_B=1'b1.
//  - Sub-module demux_slot: one-entry WIDTH-bit holding register, FSM and CNT_W counter.
//    Ports: Clk, Reset, load, ld_data, ready, valid, data, cnt.
//    Instantiated twice (A, B). The top level holds only the in_ready/load steering logic.
// TESTING
//  1. Reset=1 for 2 cycles -> in_ready=0, outA_valid=outB_valid=0, data=0, cntA=cntB=0.
//     Release Reset -> in_ready=1.
//  2. Route to A: in_data=32'h00000001, sel=0, valid=1 for 1 cycle, outA_ready=1.
//     -> next cycle outA_valid=1, outA_data=32'h00000001, outB_valid=0.
//     -> one cycle later cntA=1.
//  3. Route to B: in_data=32'h9864F1D9, sel=1, outB_ready=0.
//     -> outB holds 32'h9864F1D9.
//     A second sel=1 word 32'hF0000002 -> in_ready=0 while outB_ready=0.
//     A sel=0 word 32'hFFFFFFFF still accepted (in_ready=1) and appears on A.
//  4. Back-to-back: sel=0, outA_ready=1, words 1,2,3,4 on consecutive cycles.
//     -> in_ready=1 throughout, outA_data=1,2,3,4 on consecutive cycles, cntA=4.
//  5. Reset mid-operation: A and B both FULL (outX_ready=0), assert Reset for 1 cycle.
//     -> both valids=0, counters=0, held words never appear.
//  6. Counter wrap with CNT_W=4: 17 words delivered on B -> cntB=1, cntA unchanged.

Source files
------------

// File: rtl/demux_pkg.sv
// Shared types and helpers for the registered 1-to-2 demultiplexer.
// Holds the slot state encoding, the destination codes and the slot-acceptance rule.
package demux_pkg;

    typedef enum logic [0:0] {
        SLOT_EMPTY = 1'b0,
        SLOT_FULL  = 1'b1
    } slot_state_t;

    localparam logic SEL_A = 1'b0;
    localparam logic SEL_B = 1'b1;

    // A slot can take a new word when it is empty or its current word leaves this edge.
    function automatic logic slot_can_take(input logic valid, input logic ready);
        return (!valid) || ready;
    endfunction

endpackage

// File: rtl/demux1x2_reg_if.sv
// Stream bundle for demux1x2_reg: one valid/ready input stream and two output streams,
// plus the per-output delivered-word counters.
interface demux1x2_reg_if #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 16
);
    logic [WIDTH-1:0] in_data;
    logic             in_sel;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] outA_data;
    logic             outA_valid;
    logic             outA_ready;
    logic [WIDTH-1:0] outB_data;
    logic             outB_valid;
    logic             outB_ready;
    logic [CNT_W-1:0] cntA;
    logic [CNT_W-1:0] cntB;

    modport master (
        output in_data, in_sel, in_valid, outA_ready, outB_ready,
        input  in_ready, outA_data, outA_valid, outB_data, outB_valid, cntA, cntB
    );

    modport slave (
        input  in_data, in_sel, in_valid, outA_ready, outB_ready,
        output in_ready, outA_data, outA_valid, outB_data, outB_valid, cntA, cntB
    );
endinterface

// File: rtl/demux_slot.sv
// One-entry output holding register with its EMPTY/FULL FSM and a wrapping
// counter of words delivered to the consumer.
module demux_slot
    import demux_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = 16
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             load,
    input  logic [WIDTH-1:0] ld_data,
    input  logic             ready,
    output logic             valid,
    output logic [WIDTH-1:0] data,
    output logic [CNT_W-1:0] cnt
);

    slot_state_t      state_r;
    slot_state_t      state_s;
    logic [WIDTH-1:0] data_r;
    logic [CNT_W-1:0] cnt_r;
    logic             drain_s;

    assign drain_s = (state_r == SLOT_FULL) && ready;

    // Next-state: a load always leaves the slot full, even when the old word drains.
    always_comb begin
        state_s = state_r;
        case (state_r)
            SLOT_EMPTY: begin
                if (load) begin
                    state_s = SLOT_FULL;
                end else begin
                    state_s = SLOT_EMPTY;
                end
            end
            SLOT_FULL: begin
                if (load) begin
                    state_s = SLOT_FULL;
                end else if (ready) begin
                    state_s = SLOT_EMPTY;
                end else begin
                    state_s = SLOT_FULL;
                end
            end
            default: state_s = SLOT_EMPTY;
        endcase
    end

    // Slot state register.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_r <= SLOT_EMPTY;
        end else begin
            state_r <= state_s;
        end
    end

    // Held word: only a load changes it, so a drained slot keeps showing its last word.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            data_r <= '0;
        end else if (load) begin
            data_r <= ld_data;
        end else begin
            data_r <= data_r;
        end
    end

    // Delivered-word counter, wraps naturally at 2^CNT_W.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            cnt_r <= '0;
        end else if (drain_s) begin
            cnt_r <= cnt_r + CNT_W'(1);
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign valid = (state_r == SLOT_FULL);
    assign data  = data_r;
    assign cnt   = cnt_r;

endmodule

// File: rtl/demux1x2_reg.sv
// Registered 1-to-2 demultiplexer: steers each accepted input word into output
// slot A (in_sel=0) or B (in_sel=1); each slot stalls independently.
module demux1x2_reg
    import demux_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = 16
) (
    input  logic          Clk,
    input  logic          Reset,
    demux1x2_reg_if.slave bus
);

    logic             take_s;
    logic             load_a_s;
    logic             load_b_s;
    logic             a_valid_s;
    logic             b_valid_s;
    logic [WIDTH-1:0] a_data_s;
    logic [WIDTH-1:0] b_data_s;
    logic [CNT_W-1:0] a_cnt_s;
    logic [CNT_W-1:0] b_cnt_s;

    // in_ready looks only at the selected slot so a stalled consumer never blocks the other.
    always_comb begin
        take_s = 1'b0;
        if (Reset) begin
            take_s = 1'b0;
        end else if (bus.in_sel == SEL_B) begin
            take_s = slot_can_take(b_valid_s, bus.outB_ready);
        end else begin
            take_s = slot_can_take(a_valid_s, bus.outA_ready);
        end
    end

    assign load_a_s = bus.in_valid && take_s && (bus.in_sel == SEL_A);
    assign load_b_s = bus.in_valid && take_s && (bus.in_sel == SEL_B);

    demux_slot #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_slot_a (
        .Clk     (Clk),
        .Reset   (Reset),
        .load    (load_a_s),
        .ld_data (bus.in_data),
        .ready   (bus.outA_ready),
        .valid   (a_valid_s),
        .data    (a_data_s),
        .cnt     (a_cnt_s)
    );

    demux_slot #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_slot_b (
        .Clk     (Clk),
        .Reset   (Reset),
        .load    (load_b_s),
        .ld_data (bus.in_data),
        .ready   (bus.outB_ready),
        .valid   (b_valid_s),
        .data    (b_data_s),
        .cnt     (b_cnt_s)
    );

    assign bus.in_ready   = take_s;
    assign bus.outA_valid = a_valid_s;
    assign bus.outA_data  = a_data_s;
    assign bus.cntA       = a_cnt_s;
    assign bus.outB_valid = b_valid_s;
    assign bus.outB_data  = b_data_s;
    assign bus.cntB       = b_cnt_s;

endmodule

// File: tb/tb_demux1x2_reg.sv
// Self-checking bench for demux1x2_reg: directed scenarios plus random traffic,
// checked every cycle against a queue-based model of the two output slots.
module tb_demux1x2_reg;

    localparam int WIDTH = 32;
    localparam int CNT_W = 4;
    localparam int CNT_M = 16;

    logic clk;
    logic reset;

    int tests_run;
    int tests_failed;

    // Reference model: each output is a queue holding at most one word.
    logic [WIDTH-1:0] qa[$];
    logic [WIDTH-1:0] qb[$];
    logic [WIDTH-1:0] last_a;
    logic [WIDTH-1:0] last_b;
    int               cnt_a;
    int               cnt_b;

    demux1x2_reg_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();

    demux1x2_reg #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) dut (
        .Clk   (clk),
        .Reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests_run = tests_run + 1;
        if (obs !== exp) begin
            tests_failed = tests_failed + 1;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // One clock cycle: drive inputs, check in_ready, advance model and DUT, check outputs.
    task automatic step(input logic [WIDTH-1:0] din, input logic sel, input logic vld,
                        input logic ra, input logic rb, input logic rst);
        logic exp_ready;
        @(negedge clk);
        reset          = rst;
        bus.in_data    = din;
        bus.in_sel     = sel;
        bus.in_valid   = vld;
        bus.outA_ready = ra;
        bus.outB_ready = rb;
        #1;
        if (rst) begin
            exp_ready = 1'b0;
        end else if (sel) begin
            exp_ready = (qb.size() == 0) || rb;
        end else begin
            exp_ready = (qa.size() == 0) || ra;
        end
        check("in_ready", 64'(bus.in_ready), 64'(exp_ready));

        if (rst) begin
            qa.delete();
            qb.delete();
            last_a = '0;
            last_b = '0;
            cnt_a  = 0;
            cnt_b  = 0;
        end else begin
            if (qa.size() != 0 && ra) begin
                void'(qa.pop_front());
                cnt_a = (cnt_a + 1) % CNT_M;
            end
            if (qb.size() != 0 && rb) begin
                void'(qb.pop_front());
                cnt_b = (cnt_b + 1) % CNT_M;
            end
            if (vld && exp_ready) begin
                if (sel) begin
                    qb.push_back(din);
                    last_b = din;
                end else begin
                    qa.push_back(din);
                    last_a = din;
                end
            end
        end

        @(posedge clk);
        #1;
        check("outA_valid", 64'(bus.outA_valid), 64'(qa.size() != 0));
        check("outB_valid", 64'(bus.outB_valid), 64'(qb.size() != 0));
        check("outA_data", 64'(bus.outA_data), 64'(last_a));
        check("outB_data", 64'(bus.outB_data), 64'(last_b));
        check("cntA", 64'(bus.cntA), 64'(cnt_a));
        check("cntB", 64'(bus.cntB), 64'(cnt_b));
    endtask

    initial begin
        tests_run      = 0;
        tests_failed   = 0;
        cnt_a          = 0;
        cnt_b          = 0;
        last_a         = '0;
        last_b         = '0;
        reset          = 1'b1;
        bus.in_data    = '0;
        bus.in_sel     = 1'b0;
        bus.in_valid   = 1'b0;
        bus.outA_ready = 1'b0;
        bus.outB_ready = 1'b0;

        // Reset for two cycles, then release.
        step(32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        step(32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        check("reset_cntA", 64'(bus.cntA), 64'd0);
        step(32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        // Route one word to A, consumer ready.
        step(32'h0000_0001, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        check("t2_outA_data", 64'(bus.outA_data), 64'h1);
        step(32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        check("t2_cntA", 64'(bus.cntA), 64'd1);

        // B stalls: second B word blocked, A word still flows.
        step(32'h9864_F1D9, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        step(32'hF000_0002, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        check("t3_outB_held", 64'(bus.outB_data), 64'h9864_F1D9);
        step(32'hFFFF_FFFF, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        check("t3_outA_data", 64'(bus.outA_data), 64'hFFFF_FFFF);

        // Back-to-back words to A at full rate.
        for (int i = 1; i <= 4; i++) begin
            step(32'(i), 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
            check("t4_stream", 64'(bus.outA_data), 64'(i));
        end
        step(32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);

        // Both slots full, then reset drops the held words.
        step(32'hAAAA_5555, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        step(32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        check("t5_cntA", 64'(bus.cntA), 64'd0);
        step(32'h0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        step(32'h0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);

        // 17 deliveries on B wrap the 4-bit counter to 1.
        for (int i = 0; i < 17; i++) begin
            step(32'(32'h100 + i), 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        end
        step(32'h0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        step(32'h0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        check("t6_cntB_wrap", 64'(bus.cntB), 64'd1);
        check("t6_cntA_same", 64'(bus.cntA), 64'd0);

        // Random traffic with occasional resets.
        for (int i = 0; i < 600; i++) begin
            step($urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0),
                 1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 2) != 0),
                 1'($urandom_range(0, 63) == 0));
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
